dev_spi: RTL and testbench

DEV_SPI -- requirements
Module: dev_spi

---
 rtl/dev_spi_if.sv | 12 +
 rtl/dev_spi.sv | 138 +++++++++++++
 tb/tb_dev_spi.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/dev_spi_if.sv
// Memory-mapped bus port of the SPI master: one-cycle strobe in, one-cycle acknowledge out.
interface dev_spi_if;
  logic        stb;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] dtw;
  logic        ack;
  logic [31:0] dtr;

  modport master (output stb, we, addr, dtw, input ack, dtr);
  modport slave  (input stb, we, addr, dtw, output ack, dtr);
endinterface

// File: rtl/dev_spi.sv
// SPI master with a four-register MMIO map (CTRL, STAT, TXDATA, RXDATA) and a byte-complete interrupt.
module dev_spi #(
  parameter int DIV_BITS = 8
) (
  input  logic     clk,
  input  logic     reset,
  dev_spi_if.slave bus,
  output logic     irq,
  output logic     sck,
  output logic     mosi,
  output logic     cs_n,
  input  logic     miso
);

  // Mode bits sit above the divider field, never below bit 8.
  localparam int FB = (DIV_BITS > 8) ? DIV_BITS : 8;
  localparam logic [DIV_BITS-1:0] DIV_ONE = 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t              state_q, state_d;
  logic [DIV_BITS-1:0] div_q, div_lat_q, dcnt_q;
  logic                cpol_q, cpha_q, cs_q, ie_q;
  logic                cpol_lat_q, cpha_lat_q, sck_q;
  logic                ovr_q, rxv_q;
  logic [7:0]          sr_q, rx_q, rxdata_q;
  logic [4:0]          tcnt_q;
  logic [31:0]         rdata;
  logic                tx_wr, edge_hit, lead_edge, sample_edge;

  assign tx_wr       = bus.stb & bus.we & (bus.addr == 2'd2);
  assign edge_hit    = (state_q == XFER) && (dcnt_q == div_lat_q);
  assign lead_edge   = ~tcnt_q[0];
  assign sample_edge = lead_edge ^ cpha_lat_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_wr) state_d = XFER;
      XFER:    if (edge_hit && tcnt_q == 5'd15) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    case (bus.addr)
      2'd0: begin
        rdata[DIV_BITS-1:0] = div_q;
        rdata[FB]           = cpol_q;
        rdata[FB+1]         = cpha_q;
        rdata[FB+2]         = cs_q;
        rdata[FB+3]         = ie_q;
      end
      2'd1:    rdata[2:0] = {ovr_q, rxv_q, state_q != IDLE};
      2'd3:    rdata[7:0] = rxdata_q;
      default: rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ack    <= 1'b0;
      bus.dtr    <= '0;
      div_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      cs_q       <= 1'b0;
      ie_q       <= 1'b0;
      div_lat_q  <= '0;
      cpol_lat_q <= 1'b0;
      cpha_lat_q <= 1'b0;
      dcnt_q     <= '0;
      tcnt_q     <= '0;
      sck_q      <= 1'b0;
      sr_q       <= '0;
      rx_q       <= '0;
      rxdata_q   <= '0;
      ovr_q      <= 1'b0;
      rxv_q      <= 1'b0;
    end else begin
      bus.ack <= bus.stb;
      bus.dtr <= (bus.stb && !bus.we) ? rdata : '0;

      if (bus.stb && bus.we && bus.addr == 2'd0) begin
        div_q  <= bus.dtw[DIV_BITS-1:0];
        cpol_q <= bus.dtw[FB];
        cpha_q <= bus.dtw[FB+1];
        cs_q   <= bus.dtw[FB+2];
        ie_q   <= bus.dtw[FB+3];
      end
      if (bus.stb && bus.we && bus.addr == 2'd1 && bus.dtw[2]) ovr_q <= 1'b0;
      if (tx_wr && state_q != IDLE) ovr_q <= 1'b1;
      // A completing byte overrides a coincident RXDATA read clearing RXV.
      if (bus.stb && !bus.we && bus.addr == 2'd3) rxv_q <= 1'b0;

      case (state_q)
        IDLE: if (tx_wr) begin
          sr_q       <= bus.dtw[7:0];
          rx_q       <= '0;
          tcnt_q     <= '0;
          dcnt_q     <= '0;
          div_lat_q  <= div_q;
          cpol_lat_q <= cpol_q;
          cpha_lat_q <= cpha_q;
          sck_q      <= cpol_q;
        end
        XFER: if (edge_hit) begin
          dcnt_q <= '0;
          sck_q  <= ~sck_q;
          tcnt_q <= tcnt_q + 5'd1;
          // With CPHA=1 bit 7 is already on mosi, so the first leading edge does not shift.
          if (sample_edge) rx_q <= {rx_q[6:0], miso};
          else if (!(cpha_lat_q && tcnt_q == 5'd0)) sr_q <= {sr_q[6:0], 1'b0};
        end else begin
          dcnt_q <= dcnt_q + DIV_ONE;
        end
        DONE: begin
          rxdata_q <= rx_q;
          rxv_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sck  = (state_q == IDLE) ? cpol_q : sck_q;
  assign mosi = (state_q == XFER) ? sr_q[7] : 1'b1;
  assign cs_n = ~cs_q;
  assign irq  = ie_q & rxv_q;

endmodule

// File: tb/tb_dev_spi.sv
// Bench for dev_spi: transaction-level register/waveform model checked every cycle, plus directed literals.
module tb_dev_spi;

  logic clk = 1'b0;
  logic reset;
  logic irq, sck, mosi, cs_n, miso;
  logic loopback, miso_const;

  dev_spi_if bus ();

  dev_spi #(.DIV_BITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave),
    .irq   (irq),
    .sck   (sck),
    .mosi  (mosi),
    .cs_n  (cs_n),
    .miso  (miso)
  );

  always #5 clk = ~clk;
  assign miso = loopback ? mosi : miso_const;

  int n_chk  = 0;
  int n_fail = 0;
  int sck_rises = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_ctrl, m_dtr, m_rv;
  logic        m_ovr, m_rxv, m_act, m_ack, m_busy_pre, m_cpol, m_cpha;
  logic [7:0]  m_rxd, m_tx;
  int          m_n, m_d;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_ctrl = '0; m_ovr = 1'b0; m_rxv = 1'b0; m_act = 1'b0; m_ack = 1'b0;
        m_dtr = '0; m_rxd = '0; m_tx = '0; m_n = 0; m_d = 0; m_cpol = 1'b0; m_cpha = 1'b0;
      end else begin
        m_busy_pre = m_act;
        case (bus.addr)
          2'd0:    m_rv = m_ctrl;
          2'd1:    m_rv = {29'b0, m_ovr, m_rxv, m_busy_pre};
          2'd3:    m_rv = {24'b0, m_rxd};
          default: m_rv = '0;
        endcase
        m_ack = bus.stb;
        m_dtr = (bus.stb && !bus.we) ? m_rv : '0;
        if (bus.stb && !bus.we && bus.addr == 2'd3) m_rxv = 1'b0;
        if (m_act) begin
          m_n++;
          if (m_n == 16 * (m_d + 1) + 1) begin
            m_act = 1'b0;
            m_rxd = loopback ? m_tx : {8{miso_const}};
            m_rxv = 1'b1;
          end
        end
        if (bus.stb && bus.we) begin
          case (bus.addr)
            2'd0: m_ctrl = bus.dtw & 32'hFFF;
            2'd1: if (bus.dtw[2]) m_ovr = 1'b0;
            2'd2: if (m_busy_pre) m_ovr = 1'b1;
                  else begin
                    m_act = 1'b1; m_n = 0; m_d = int'(m_ctrl[7:0]);
                    m_cpol = m_ctrl[8]; m_cpha = m_ctrl[9]; m_tx = bus.dtw[7:0];
                  end
            default: ;
          endcase
        end
      end
    end
  end

  function automatic logic exp_sck();
    int t;
    if (!m_act) return m_ctrl[8];
    t = m_n / (m_d + 1);
    if (t > 16) t = 16;
    return m_cpol ^ t[0];
  endfunction

  function automatic logic exp_mosi();
    int t, b;
    if (!m_act || m_n >= 16 * (m_d + 1)) return 1'b1;
    t = m_n / (m_d + 1);
    if (m_cpha) b = 7 - ((t == 0) ? 0 : (t - 1) / 2);
    else        b = 7 - t / 2;
    return m_tx[b];
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      chk("ack",  {31'b0, bus.ack}, {31'b0, m_ack});
      chk("dtr",  bus.dtr, m_dtr);
      chk("sck",  {31'b0, sck},  {31'b0, exp_sck()});
      chk("mosi", {31'b0, mosi}, {31'b0, exp_mosi()});
      chk("cs_n", {31'b0, cs_n}, {31'b0, ~m_ctrl[10]});
      chk("irq",  {31'b0, irq},  {31'b0, m_ctrl[11] & m_rxv});
    end
  end

  initial begin
    forever begin
      @(posedge sck);
      sck_rises++;
    end
  end

  task automatic bus_op(input logic w, input logic [1:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    @(negedge clk);
    #1;
    bus.stb = 1'b1; bus.we = w; bus.addr = a; bus.dtw = d;
    @(negedge clk);
    rd = bus.dtr;
    chk("ack_latency", {31'b0, bus.ack}, 32'd1);
    #1;
    bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.dtw = '0;
  endtask

  logic [31:0] rd;
  int cyc, tg;
  logic last_sck;

  initial begin
    bus.stb = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.dtw = '0;
    loopback = 1'b1; miso_const = 1'b0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", {31'b0, cs_n}, 32'd1);
    chk("rst_mosi", {31'b0, mosi}, 32'd1);
    #1 reset = 1'b0;

    // Register readback with nothing pending
    bus_op(1'b1, 2'd0, 32'hFFFF_F2A7, rd);
    bus_op(1'b0, 2'd0, 32'h0, rd); chk("ctrl_read", rd, 32'h0000_02A7);
    bus_op(1'b0, 2'd1, 32'h0, rd); chk("stat_idle", rd, 32'h0);
    bus_op(1'b0, 2'd2, 32'h0, rd); chk("txdata_read", rd, 32'h0);
    bus_op(1'b0, 2'd3, 32'h0, rd); chk("rxdata_reset", rd, 32'h0);

    // Mode 0, DIV=0, loopback 0xA5; RXDATA read lands on the DONE cycle
    bus_op(1'b1, 2'd0, 32'h400, rd);
    chk("cs_asserted", {31'b0, cs_n}, 32'd0);
    sck_rises = 0;
    bus_op(1'b1, 2'd2, 32'hA5, rd);
    repeat (15) @(negedge clk);
    bus_op(1'b0, 2'd3, 32'h0, rd); chk("done_collide_old", rd, 32'h0);
    chk("sck_pulses", sck_rises, 32'd8);
    bus_op(1'b0, 2'd1, 32'h0, rd); chk("stat_rxv", rd, 32'h2);
    bus_op(1'b0, 2'd3, 32'h0, rd); chk("rx_a5", rd, 32'hA5);
    bus_op(1'b0, 2'd1, 32'h0, rd); chk("stat_cleared", rd, 32'h0);

    // Overrun: second write during BUSY is dropped
    bus_op(1'b1, 2'd2, 32'h5A, rd);
    bus_op(1'b1, 2'd2, 32'h11, rd);
    repeat (20) @(negedge clk);
    bus_op(1'b0, 2'd1, 32'h0, rd); chk("stat_ovr", rd, 32'h6);
    bus_op(1'b0, 2'd3, 32'h0, rd); chk("rx_5a", rd, 32'h5A);
    bus_op(1'b1, 2'd1, 32'h4, rd);
    bus_op(1'b0, 2'd1, 32'h0, rd); chk("ovr_clear", rd, 32'h0);

    // Mode 3, DIV=3, IE, miso tied high
    loopback = 1'b0; miso_const = 1'b1;
    bus_op(1'b1, 2'd0, 32'hB03, rd);
    chk("sck_idle_high", {31'b0, sck}, 32'd1);
    bus_op(1'b1, 2'd2, 32'h3C, rd);
    cyc = 0;
    while (!irq && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("irq_latency", cyc, 32'd65);
    bus_op(1'b0, 2'd3, 32'h0, rd); chk("rx_ff", rd, 32'hFF);
    chk("irq_drop", {31'b0, irq}, 32'd0);

    // Reset at the 5th sck toggle
    loopback = 1'b1;
    bus_op(1'b1, 2'd0, 32'h401, rd);
    bus_op(1'b1, 2'd2, 32'h96, rd);
    last_sck = sck; tg = 0; cyc = 0;
    while (tg < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (sck !== last_sck) begin tg++; last_sck = sck; end
    end
    chk("toggle5_reached", tg, 32'd5);
    #1 reset = 1'b1;
    #1;
    chk("arst_sck",  {31'b0, sck},  32'd0);
    chk("arst_mosi", {31'b0, mosi}, 32'd1);
    chk("arst_cs_n", {31'b0, cs_n}, 32'd1);
    chk("arst_irq",  {31'b0, irq},  32'd0);
    chk("arst_ack",  {31'b0, bus.ack}, 32'd0);
    chk("arst_dtr",  bus.dtr, 32'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    bus_op(1'b0, 2'd1, 32'h0, rd); chk("stat_after_rst", rd, 32'h0);
    bus_op(1'b0, 2'd0, 32'h0, rd); chk("ctrl_after_rst", rd, 32'h0);
    bus_op(1'b0, 2'd3, 32'h0, rd); chk("rx_after_rst", rd, 32'h0);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

endmodule
